// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_pkg;

   typedef enum logic {
      ST_RUN      = 1'b0,
      ST_MEM_WAIT = 1'b1
   } hz_state_e;

   localparam logic [4:0]  REG_ZERO     = 5'd0;
   localparam int unsigned WAIT_MAX_DEF = 16;
   localparam int unsigned CNT_W_DEF    = 8;
   localparam int unsigned REG_IDX_W    = 5;
   localparam int unsigned PERF_CNT_W   = 32;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: datapath hazard sources, memory handshake and pipeline strobes.
interface pipe_hazard_ctrl_if;
   import pipe_pkg::*;

   logic [REG_IDX_W-1:0] ID_rs;
   logic [REG_IDX_W-1:0] ID_rt;
   logic                 EX_MemRead;
   logic [REG_IDX_W-1:0] EX_wreg;
   logic                 EX_branchTaken;
   logic                 MEM_MemRead;
   logic                 MEM_MemWrite;
   logic                 mem_ack;

   logic                 mem_req;
   logic                 pc_en;
   logic                 if_id_en;
   logic                 if_id_flush;
   logic                 id_ex_en;
   logic                 id_ex_flush;
   logic                 ex_mem_en;
   logic                 mem_wb_flush;
   logic                 mem_err;

   // Datapath / memory side
   modport master (
      output ID_rs, ID_rt, EX_MemRead, EX_wreg, EX_branchTaken,
             MEM_MemRead, MEM_MemWrite, mem_ack,
      input  mem_req, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
             ex_mem_en, mem_wb_flush, mem_err
   );

   // Controller side
   modport slave (
      input  ID_rs, ID_rt, EX_MemRead, EX_wreg, EX_branchTaken,
             MEM_MemRead, MEM_MemWrite, mem_ack,
      output mem_req, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
             ex_mem_en, mem_wb_flush, mem_err
   );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use comparator: a load in EX whose destination feeds rs/rt of the instruction in ID.
module hazard_detect
   import pipe_pkg::*;
(
   input  logic [REG_IDX_W-1:0] ID_rs,
   input  logic [REG_IDX_W-1:0] ID_rt,
   input  logic                 EX_MemRead,
   input  logic [REG_IDX_W-1:0] EX_wreg,
   output logic                 lu_hazard
);

   // $zero is never a real dependency
   assign lu_hazard = EX_MemRead && (EX_wreg != REG_ZERO) &&
                      ((EX_wreg == ID_rs) || (EX_wreg == ID_rt));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: memory wait FSM with timeout, branch flush, load-use stall.
// Optional PIPE_HAZARD_CTRL_PERF_EN adds saturating stall_cnt / flush_cnt outputs.
module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int unsigned WAIT_MAX = WAIT_MAX_DEF,
   parameter int unsigned CNT_W    = CNT_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   pipe_hazard_ctrl_if.slave     hz
`ifdef PIPE_HAZARD_CTRL_PERF_EN
   ,
   output logic [PERF_CNT_W-1:0] stall_cnt,
   output logic [PERF_CNT_W-1:0] flush_cnt
`endif
);

   hz_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;

   logic mem_acc;
   logic mem_req_c;
   logic mem_stall_c;
   logic lu_hazard;
   logic br_flush_c;
   logic lu_stall_c;

   hazard_detect u_hazard_detect (
      .ID_rs      (hz.ID_rs),
      .ID_rt      (hz.ID_rt),
      .EX_MemRead (hz.EX_MemRead),
      .EX_wreg    (hz.EX_wreg),
      .lu_hazard  (lu_hazard)
   );

   // Once timed out, accesses complete without a request so the pipeline never hangs
   assign mem_acc     = hz.MEM_MemRead | hz.MEM_MemWrite;
   assign mem_req_c   = mem_acc & ~err_q;
   assign mem_stall_c = mem_req_c & ~hz.mem_ack;
   assign br_flush_c  = ~mem_stall_c & hz.EX_branchTaken;
   assign lu_stall_c  = ~mem_stall_c & ~hz.EX_branchTaken & lu_hazard;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RUN;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   // Wait-state FSM and timeout counter
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      unique case (state_q)
         ST_RUN: begin
            if (mem_stall_c) begin
               state_d = ST_MEM_WAIT;
               cnt_d   = CNT_W'(1);
            end else begin
               cnt_d   = '0;
            end
         end
         ST_MEM_WAIT: begin
            if (!mem_stall_c) begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end else if (cnt_q == CNT_W'(WAIT_MAX)) begin
               state_d = ST_RUN;
               cnt_d   = '0;
               err_d   = 1'b1;
            end else begin
               cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_RUN;
            cnt_d   = '0;
         end
      endcase
   end

   // Strobe priority: memory stall > taken branch > load-use
   always_comb begin
      hz.mem_req      = mem_req_c;
      hz.pc_en        = 1'b1;
      hz.if_id_en     = 1'b1;
      hz.if_id_flush  = 1'b0;
      hz.id_ex_en     = 1'b1;
      hz.id_ex_flush  = 1'b0;
      hz.ex_mem_en    = 1'b1;
      hz.mem_wb_flush = 1'b0;
      if (mem_stall_c) begin
         hz.pc_en        = 1'b0;
         hz.if_id_en     = 1'b0;
         hz.id_ex_en     = 1'b0;
         hz.ex_mem_en    = 1'b0;
         hz.mem_wb_flush = 1'b1;
      end else if (br_flush_c) begin
         hz.if_id_flush  = 1'b1;
         hz.id_ex_flush  = 1'b1;
      end else if (lu_stall_c) begin
         hz.pc_en        = 1'b0;
         hz.if_id_en     = 1'b0;
         hz.id_ex_flush  = 1'b1;
      end
   end

   assign hz.mem_err = err_q;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
   // Saturating event counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if ((mem_stall_c || lu_stall_c) && (stall_cnt != '1))
            stall_cnt <= stall_cnt + PERF_CNT_W'(1);
         if (br_flush_c && (flush_cnt != '1))
            flush_cnt <= flush_cnt + PERF_CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (WAIT_MAX=4); checks strobe vectors per cycle and perf counters when enabled.
module tb_pipe_hazard_ctrl;
   import pipe_pkg::*;

   // {mem_req, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush, mem_err}
   localparam logic [8:0] P_IDLE = 9'b0_1_1_0_1_0_1_0_0;
   localparam logic [8:0] P_LU   = 9'b0_0_0_0_1_1_1_0_0;
   localparam logic [8:0] P_BR   = 9'b0_1_1_1_1_1_1_0_0;
   localparam logic [8:0] P_ZW   = 9'b1_1_1_0_1_0_1_0_0;
   localparam logic [8:0] P_MST  = 9'b1_0_0_0_0_0_0_1_0;
   localparam logic [8:0] P_ERR  = 9'b0_1_1_0_1_0_1_0_1;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   pipe_hazard_ctrl_if hz ();

`ifdef PIPE_HAZARD_CTRL_PERF_EN
   logic [31:0] stall_cnt;
   logic [31:0] flush_cnt;
`endif

   pipe_hazard_ctrl #(.WAIT_MAX(4), .CNT_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .hz        (hz)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
      ,
      .stall_cnt (stall_cnt),
      .flush_cnt (flush_cnt)
`endif
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [8:0] obs();
      return {hz.mem_req, hz.pc_en, hz.if_id_en, hz.if_id_flush, hz.id_ex_en,
              hz.id_ex_flush, hz.ex_mem_en, hz.mem_wb_flush, hz.mem_err};
   endfunction

   task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic ex_mr,
                        input logic [4:0] wreg, input logic br, input logic mr,
                        input logic mw, input logic ack);
      hz.ID_rs          = rs;
      hz.ID_rt          = rt;
      hz.EX_MemRead     = ex_mr;
      hz.EX_wreg        = wreg;
      hz.EX_branchTaken = br;
      hz.MEM_MemRead    = mr;
      hz.MEM_MemWrite   = mw;
      hz.mem_ack        = ack;
   endtask

   task automatic idle();
      drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Inputs are applied just after a falling edge; check mid-phase, then move to the next falling edge
   task automatic cyc(input string tag, input logic [8:0] exp);
      #1;
      check(tag, 32'(obs()), 32'(exp));
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      #1;
      check("reset", 32'(obs()), 32'(P_IDLE));
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Load-use on rs, then clears next cycle
      drive(5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0); cyc("lu_rs", P_LU);
      idle();                                                cyc("lu_done", P_IDLE);
      drive(5'd3, 5'd7, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0); cyc("lu_rt", P_LU);
      drive(5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); cyc("lu_r0", P_IDLE);
      drive(5'd5, 5'd5, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0); cyc("lu_noload", P_IDLE);

      // Taken branch overrides load-use
      drive(5'd5, 5'd0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0); cyc("br_lu", P_BR);

      // Zero-wait store
      drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1); cyc("zw_store", P_ZW);
      idle();                                                cyc("zw_after", P_IDLE);

      // Fresh counters before the perf scenario
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      @(negedge clk);
`ifdef PIPE_HAZARD_CTRL_PERF_EN
      check("perf_rst_stall", stall_cnt, 32'd0);
      check("perf_rst_flush", flush_cnt, 32'd0);
`endif

      // 3-wait load, ack on the 4th cycle, then one branch
      drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0); cyc("w3_c1", P_MST);
      cyc("w3_c2", P_MST);
      cyc("w3_c3", P_MST);
      hz.mem_ack = 1'b1;                                     cyc("w3_ack", P_ZW);
      idle();                                                cyc("w3_run", P_IDLE);
      drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0); cyc("br", P_BR);
      idle();                                                cyc("br_after", P_IDLE);
`ifdef PIPE_HAZARD_CTRL_PERF_EN
      check("perf_stall", stall_cnt, 32'd3);
      check("perf_flush", flush_cnt, 32'd1);
`endif

      // Timeout: 5 stalled cycles, then sticky error and no request
      drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 1; i <= 5; i++) cyc($sformatf("to_c%0d", i), P_MST);
      cyc("to_err", P_ERR);
      drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0); cyc("to_store", P_ERR);
      idle();                                                cyc("to_idle", P_ERR);

      // Reset clears the sticky error
      rst_n = 1'b0;
      #1;
      check("rst_err", 32'(obs()), 32'(P_IDLE));
      #1;
      rst_n = 1'b1;
      @(negedge clk);

      // Reset mid-wait, then a full timeout again proves the counter restarted
      drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 1; i <= 3; i++) cyc($sformatf("mw_c%0d", i), P_MST);
      idle();
      rst_n = 1'b0;
      #1;
      check("rst_midwait", 32'(obs()), 32'(P_IDLE));
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 1; i <= 5; i++) cyc($sformatf("to2_c%0d", i), P_MST);
      cyc("to2_err", P_ERR);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
